rom_fetch: RTL and testbench
============================

ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, ROM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, ROM address width; ROM depth is 2**ADDR_WIDTH.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 Ports, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first ROM address
- len  in  ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH
- busy  out  1  burst in progress
- done  out  1  one-cycle end-of-burst pulse
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_ena  out  1  read request to ROM
- rom_data  in  DATA_WIDTH  ROM read data
- out_data  out  DATA_WIDTH  stream data
- out_addr  out  ADDR_WIDTH  address of out_data
- out_valid  out  1  stream valid
- out_ready  in  1  consumer ready
- out_sum  out  DATA_WIDTH  burst checksum

Function
REQ-005 The ROM captures rom_addr on the falling edge of clk when rom_ena=1. rom_fetch SHALL sample rom_data on the first rising edge after the edge that registered rom_ena=1; the read latency is fixed at 1 cycle.
REQ-006 The FSM SHALL have the states IDLE, FETCH, DRAIN and FIN.
- IDLE->FETCH on start with len!=0.
- IDLE->FIN on start with len=0.
- FETCH->DRAIN after the last request is issued.
- DRAIN->FIN when the buffer is empty, nothing is in flight and the last word has been accepted.
- FIN->IDLE after 1 cycle.
REQ-007 A request SHALL be issued only when buffer occupancy plus in-flight reads is less than 2. On a request rom_ena=1 for exactly that cycle; otherwise rom_ena=0. rom_addr SHALL hold its last value while idle.
REQ-008 Addresses SHALL increment by 1 per request and wrap modulo 2**ADDR_WIDTH (e.g. 15->0 for ADDR_WIDTH=4).
REQ-009 Returned words SHALL enter a 2-entry FIFO together with their address. The FIFO SHALL never overflow or drop a word.
REQ-010 out_valid/out_ready: a word transfers when both are 1. While out_valid=1 and out_ready=0, out_data and out_addr SHALL remain stable.
REQ-011 With the consumer always ready, SHALL sustain 1 word per cycle after the initial 1-cycle latency.
REQ-012 busy=1 in FETCH and DRAIN, 0 otherwise. done=1 only in FIN.
REQ-013 start SHALL be ignored while busy=1 or in FIN.
REQ-014 len=2**ADDR_WIDTH SHALL read every location exactly once, starting at start_addr.

Reset
REQ-015 When rst=1 at a clock edge: FSM goes to IDLE, FIFO is emptied, in-flight reads are discarded, and busy, done, rom_ena, out_valid, rom_addr, out_data, out_addr and out_sum are all 0.
REQ-016 rst SHALL take priority over start and over every in-progress transfer, including a reset mid-burst.

Configuration
REQ-017 Macro ROM_FETCH_CHECKSUM_EN:
- When defined, out_sum SHALL be the sum modulo 2**DATA_WIDTH of all words transferred in the current burst. It is cleared on an accepted start and is valid when done=1.
- When undefined, out_sum SHALL be constant 0 and no adder is synthesized.

Structure
REQ-018 Package rom_pkg SHALL hold the default widths and the FSM state typedef.
REQ-019 The 2-entry FIFO SHALL be a sub-module named rom_fetch_fifo with parameter WIDTH = DATA_WIDTH+ADDR_WIDTH.

Verification
ROM model content for all scenarios: rom[a] = 3*a mod 128, ADDR_WIDTH=4, DATA_WIDTH=7.
REQ-020 start_addr=2, len=4, out_ready=1 -> out_data 6,9,12,15 on consecutive cycles; out_addr 2..5; done pulses once; out_sum=42 when the macro is defined.
REQ-021 start_addr=14, len=4 -> out_addr 14,15,0,1; out_data 42,45,0,3.
REQ-022 len=0 -> rom_ena never asserted, done=1 one cycle after start, busy stays 0.
REQ-023 len=3, out_ready held 0 for 5 cycles -> at most 2 rom_ena pulses, out_data holds 0 (addr 0), no word lost once out_ready=1.
REQ-024 rst asserted during the third word of a len=8 burst -> next cycle all outputs 0 and IDLE; a new start then reads correctly from start_addr.
REQ-025 start pulsed while busy -> ignored; the current burst completes unchanged.

Source files
------------

// File: rtl/rom_pkg.sv
// -----------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the ROM burst fetch engine.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default ROM word and address widths
//   FIFO_DEPTH                      : entries in the return buffer
//   fetch_state_t                   : burst controller states
// -----------------------------------------------------------------------------
package rom_pkg;

  localparam int DEF_DATA_WIDTH = 7;
  localparam int DEF_ADDR_WIDTH = 4;

  // The request throttle allows at most this many words to be either
  // buffered or on their way back from the ROM.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/rom_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rom_fetch_fifo
// Two-entry first-word-fall-through buffer holding returned ROM words together
// with their addresses. Entry 0 is always the head, so the head output is a
// plain register and stays stable while the consumer stalls.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, clears contents and count
//   push      in   write push_data this cycle
//   push_data in   WIDTH-bit word to store
//   pop       in   remove the head entry this cycle (ignored when empty)
//   head_data out  current head entry
//   count     out  number of valid entries (0..2)
//   empty     out  no valid entries
// -----------------------------------------------------------------------------
module rom_fetch_fifo
  import rom_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + DEF_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             pop_ok;
  logic             push_ok;

  // Pops on an empty buffer are dropped; a push into a full buffer is only
  // accepted when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && ((count != 2'd2) || pop_ok);
  end

  // Shift-style storage: a pop moves entry 1 into the head slot, a push
  // lands in the first free slot after the pop has been applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= push_data;
          end else begin
            entry1 <= push_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_data = entry0;
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/rom_fetch.sv
// -----------------------------------------------------------------------------
// rom_fetch
// Burst reader for a synchronous ROM with one cycle of read latency. A start
// pulse in IDLE launches a burst of len consecutive (wrapping) addresses from
// start_addr; returned words are streamed out over a valid/ready interface
// with their addresses attached.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a burst (only looked at in IDLE)
//   start_addr in   first ROM address of the burst
//   len        in   number of words, 0..2**ADDR_WIDTH
//   busy       out  burst in progress (FETCH or DRAIN)
//   done       out  one-cycle pulse in FIN
//   rom_addr   out  address presented to the ROM, held while idle
//   rom_ena    out  one-cycle read request
//   rom_data   in   ROM read data, valid the cycle after a request
//   out_data   out  streamed word
//   out_addr   out  address of out_data
//   out_valid  out  stream valid
//   out_ready  in   consumer ready
//   out_sum    out  running burst checksum
// Build option: define ROM_FETCH_CHECKSUM_EN to compute out_sum as the
// modulo-2**DATA_WIDTH sum of the words delivered in the current burst;
// otherwise out_sum is tied to zero and no adder exists.
// -----------------------------------------------------------------------------
module rom_fetch
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ena,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum
);

  localparam int FIFO_WIDTH = DATA_WIDTH + ADDR_WIDTH;

  fetch_state_t              state;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [ADDR_WIDTH:0]       remaining;
  logic [FIFO_WIDTH-1:0]     fifo_head;
  logic [1:0]                fifo_count;
  logic                      fifo_empty;
  logic                      pop;
  logic [2:0]                occ_next;
  logic                      can_issue;
  logic                      drain_done;

  // The read issued last cycle (rom_ena still high) lands in the buffer on
  // this edge together with the address it was issued for.
  rom_fetch_fifo #(
    .WIDTH(FIFO_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rom_ena),
    .push_data ({rom_addr, rom_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_addr  = fifo_head[FIFO_WIDTH-1:DATA_WIDTH];
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign pop       = out_valid && out_ready;

  // Buffer occupancy right after this edge: the in-flight word arrives and
  // the head may leave. With only a single cycle of latency, the returning
  // word is the only one that can be in flight, so a new request is safe
  // whenever that post-edge occupancy leaves room for it. In steady state
  // (consumer always ready) this settles at one word and issues every cycle.
  always_comb begin
    occ_next   = 3'(fifo_count) + 3'(rom_ena) - 3'(pop);
    can_issue  = (occ_next < 3'(FIFO_DEPTH));
    drain_done = !rom_ena && (occ_next == 3'd0);
  end

  // Burst controller. rom_ena is a registered one-cycle request and rom_addr
  // only moves when a request is made, so it holds its value between bursts.
  // start is only examined in IDLE, which makes it ignored while busy and in
  // FIN. The first request is launched on the same edge that accepts start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_ena   <= 1'b0;
      rom_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      rom_ena <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              busy      <= 1'b1;
              rom_ena   <= 1'b1;
              rom_addr  <= start_addr;
              next_addr <= start_addr + 1'b1;
              remaining <= len - 1'b1;
            end
          end
        end
        FETCH: begin
          if (remaining == '0) begin
            state <= DRAIN;
          end else if (can_issue) begin
            rom_ena   <= 1'b1;
            rom_addr  <= next_addr;
            next_addr <= next_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_WIDTH + 1)'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROM_FETCH_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  // Accumulates every delivered word; the last word is added on the same
  // edge that enters FIN, so the value is complete while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if ((state == IDLE) && start) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + out_data;
    end
  end

  assign out_sum = sum_q;
`else
  assign out_sum = '0;
`endif

endmodule

// File: tb/tb_rom_fetch.sv
module tb_rom_fetch;

  localparam int DW = 7;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic          rom_ena;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            passed = 0;
  int            fails = 0;
  int            cycle = 0;
  int            ena_count = 0;
  int            done_count = 0;
  int            xfer_count = 0;
  int            first_xfer = 0;
  int            last_xfer = 0;
  bit            busy_seen = 1'b0;
  logic [DW-1:0] exp_sum = '0;
  bit            sum_en;

  rom_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_ena    (rom_ena),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum)
  );

  always #5 clk = ~clk;

  // ROM contents: rom[a] = 3*a mod 128
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'((3 * int'(a)) % 128);
  endfunction

  // ROM captures the address on the falling edge when enabled
  always @(negedge clk) begin
    if (rom_ena) rom_data <= rom_word(rom_addr);
  end

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard compare of one delivered word
  task automatic checkOutput(input beat_t seen);
    beat_t e;
    expectEq("word_expected", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      expectEq("out_addr", 32'(seen.addr), 32'(e.addr));
      expectEq("out_data", 32'(seen.data), 32'(e.data));
    end
    if (xfer_count == 0) first_xfer = cycle;
    last_xfer = cycle;
    xfer_count++;
  endtask

  // One clock: transfer condition is captured before the edge, status after
  task automatic tick();
    bit    xfer;
    beat_t seen;
    xfer = out_valid && out_ready;
    seen = {out_addr, out_data};
    @(posedge clk);
    if (xfer) checkOutput(seen);
    @(negedge clk);
    cycle++;
    if (rom_ena) ena_count++;
    if (done) done_count++;
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic resetCounters();
    ena_count  = 0;
    done_count = 0;
    xfer_count = 0;
    busy_seen  = 1'b0;
  endtask

  // Drive a start pulse and load the scoreboard with the expected burst
  task automatic applyStimulus(input logic [AW-1:0] addr, input int n);
    logic [AW-1:0] a;
    a       = addr;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, rom_word(a)});
      exp_sum = exp_sum + rom_word(a);
      a = a + 1'b1;
    end
    start      = 1'b1;
    start_addr = addr;
    len        = (AW + 1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int bound, input bit rnd_ready);
    int n;
    n = 0;
    while (!done && n < bound) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    expectEq({tag, "_done"}, 32'(done), 1);
    if (done) begin
      expectEq({tag, "_sum"}, 32'(out_sum), sum_en ? 32'(exp_sum) : 32'd0);
      expectEq({tag, "_drained"}, 32'(exp_q.size()), 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic checkIdleZero(input string tag);
    expectEq({tag, "_busy"}, 32'(busy), 0);
    expectEq({tag, "_done"}, 32'(done), 0);
    expectEq({tag, "_rom_ena"}, 32'(rom_ena), 0);
    expectEq({tag, "_out_valid"}, 32'(out_valid), 0);
    expectEq({tag, "_rom_addr"}, 32'(rom_addr), 0);
    expectEq({tag, "_out_data"}, 32'(out_data), 0);
    expectEq({tag, "_out_addr"}, 32'(out_addr), 0);
    expectEq({tag, "_out_sum"}, 32'(out_sum), 0);
  endtask

  initial begin
`ifdef ROM_FETCH_CHECKSUM_EN
    sum_en = 1'b1;
`else
    sum_en = 1'b0;
`endif
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    checkIdleZero("reset");
    rst = 1'b0;
    tick();

    $display("[TB] burst addr 2 len 4, consumer always ready");
    out_ready = 1'b1;
    resetCounters();
    applyStimulus(4'd2, 4);
    waitDone("burst4", 40, 1'b0);
    expectEq("burst4_xfers", 32'(xfer_count), 4);
    expectEq("burst4_back_to_back", 32'(last_xfer - first_xfer), 3);
    tick();
    tick();
    expectEq("burst4_done_pulses", 32'(done_count), 1);
    expectEq("burst4_rom_addr_hold", 32'(rom_addr), 5);

    $display("[TB] burst wrapping past the top address");
    resetCounters();
    applyStimulus(4'd14, 4);
    waitDone("wrap", 40, 1'b0);
    expectEq("wrap_xfers", 32'(xfer_count), 4);
    expectEq("wrap_back_to_back", 32'(last_xfer - first_xfer), 3);
    tick();

    $display("[TB] zero-length burst");
    resetCounters();
    applyStimulus(4'd5, 0);
    expectEq("len0_done_next", 32'(done), 1);
    expectEq("len0_busy", 32'(busy), 0);
    expectEq("len0_sum", 32'(out_sum), 0);
    tick();
    expectEq("len0_done_clear", 32'(done), 0);
    tick();
    expectEq("len0_rom_ena", 32'(ena_count), 0);
    expectEq("len0_busy_seen", 32'(busy_seen), 0);
    expectEq("len0_done_pulses", 32'(done_count), 1);

    $display("[TB] consumer stalled at burst start");
    out_ready = 1'b0;
    resetCounters();
    applyStimulus(4'd0, 3);
    for (int i = 0; i < 5; i++) tick();
    expectEq("stall_rom_ena", 32'(ena_count), 2);
    expectEq("stall_valid", 32'(out_valid), 1);
    expectEq("stall_out_data", 32'(out_data), 0);
    expectEq("stall_out_addr", 32'(out_addr), 0);
    out_ready = 1'b1;
    waitDone("stall", 40, 1'b0);
    expectEq("stall_xfers", 32'(xfer_count), 3);
    tick();

    $display("[TB] start pulsed while busy and in FIN");
    resetCounters();
    applyStimulus(4'd8, 5);
    tick();
    tick();
    start      = 1'b1;
    start_addr = 4'd0;
    len        = 5'd2;
    tick();
    start = 1'b0;
    waitDone("ignore", 40, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    expectEq("ignore_xfers", 32'(xfer_count), 5);
    expectEq("ignore_rom_ena", 32'(ena_count), 5);
    expectEq("ignore_done_pulses", 32'(done_count), 1);
    expectEq("ignore_idle_busy", 32'(busy), 0);

    $display("[TB] reset during the third word of a len 8 burst");
    resetCounters();
    applyStimulus(4'd3, 8);
    for (int i = 0; i < 20 && xfer_count < 2; i++) tick();
    expectEq("midrst_two_words", 32'(xfer_count), 2);
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    checkIdleZero("midrst");
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    expectEq("midrst_quiet_valid", 32'(out_valid), 0);
    resetCounters();
    out_ready = 1'b1;
    applyStimulus(4'd1, 3);
    waitDone("after_rst", 40, 1'b0);
    expectEq("after_rst_xfers", 32'(xfer_count), 3);
    tick();

    $display("[TB] full-depth burst with random backpressure");
    resetCounters();
    applyStimulus(4'd9, 16);
    waitDone("full", 300, 1'b1);
    expectEq("full_xfers", 32'(xfer_count), 16);
    expectEq("full_rom_ena", 32'(ena_count), 16);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
